tri_stream_tx: RTL and testbench

- Transmit side of the triangle packet stream consumed by the raster cores.
- Reads triangle records (10 × 32-bit words each) from an SDP BRAM and emits them as AXI-stream packets.
- After the last record it appends one end-triangle packet, which pushes every core into writeback.
- Sits between the triangle setup buffer and the broadcast fan-out; m_ready is the AND of all core ready signals.

---
 rtl/tri_stream_pkg.sv | 30 +++
 rtl/tri_prefetch_fifo.sv | 51 +++++
 rtl/tri_stream_tx.sv | 177 +++++++++++++++++
 tb/tb_tri_stream_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tri_stream_pkg.sv
// Shared definitions for the triangle stream transmitter.
// Used by tri_stream_tx and tri_prefetch_fifo.
package tri_stream_pkg;

    localparam int          WORDS_PER_TRI = 10;
    // Header word 0 of the terminating packet: y_start=63, y_end=63.
    localparam logic [31:0] END_HEADER    = 32'h0000_0FFF;

    // Triangle header field positions (word 0 of each record)
    localparam int Y_START_LSB = 0;
    localparam int Y_START_W   = 6;
    localparam int Y_END_LSB   = 6;
    localparam int Y_END_W     = 6;
    localparam int X_LEN_LSB   = 12;
    localparam int X_LEN_W     = 8;
    localparam int TID_LSB     = 20;
    localparam int TID_W       = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        END_PKT = 2'd2
    } tx_state_e;

    // Limit the requested triangle count to what the source buffer can hold.
    function automatic logic [5:0] clamp_tris(input logic [5:0] n, input int max_tris);
        return (int'(n) > max_tris) ? 6'(max_tris) : n;
    endfunction

endpackage

// File: rtl/tri_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched BRAM words.
// Head word is presented combinationally on dout.
module tri_prefetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/tri_stream_tx.sv
// Triangle stream transmitter: reads 10-word triangle records from a BRAM
// through a prefetch FIFO and emits them as AXI-stream packets, followed by
// one end-triangle packet that drives the raster cores into writeback.
// Optional: define TRI_STREAM_STALL_CNT_EN to add the stall_cycles counter.
module tri_stream_tx
    import tri_stream_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_TRIS     = 51
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [5:0]  tri_count,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [8:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last
`ifdef TRI_STREAM_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    tx_state_e state, state_nxt;

    logic [5:0]              tris_q;
    logic [5:0]              tris_clamped;
    logic [9:0]              total_words;
    logic [8:0]              rd_addr_q;
    logic [9:0]              xfer_cnt;
    logic [3:0]              wcnt;
    logic [BRAM_LATENCY-1:0] vld_pipe;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic [31:0]             fifo_dout;
    logic                    fifo_pop;
    logic                    start_acc;
    logic                    xfer;
    logic                    last_beat;
    logic                    words_left;
    logic                    room;
    logic [7:0]              inflight;
    logic [8:0]              occ_sum;

    assign tris_clamped = clamp_tris(tri_count, MAX_TRIS);
    assign start_acc    = start && (state == IDLE);
    assign total_words  = 10'(tris_q) * 10'(WORDS_PER_TRI);
    assign xfer         = m_valid && m_ready;
    assign last_beat    = (wcnt == 4'(WORDS_PER_TRI-1));
    assign words_left   = ({1'b0, rd_addr_q} < total_words);
    assign rd_addr      = rd_addr_q;
    assign fifo_pop     = (state == STREAM) && xfer;

    // Count reads still travelling through the BRAM pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + 8'(vld_pipe[i]);
    end

    // Only issue a read if every outstanding word is guaranteed a FIFO slot
    assign occ_sum = 9'(fifo_count) + 9'(inflight);
    assign room    = (occ_sum < 9'(FIFO_DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; an empty frame goes straight to the end packet
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (tris_clamped == 6'd0) ? END_PKT : STREAM;
            STREAM:  if (xfer && (xfer_cnt == total_words - 10'd1)) state_nxt = END_PKT;
            END_PKT: if (xfer && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: FIFO head in STREAM, synthesized end packet in END_PKT
    always_comb begin
        busy    = 1'b0;
        rd_en   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        case (state)
            STREAM: begin
                busy    = 1'b1;
                rd_en   = words_left && room;
                m_valid = !fifo_empty;
                m_data  = fifo_dout;
                m_last  = last_beat && !fifo_empty;
            end
            END_PKT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = (wcnt == 4'd0) ? END_HEADER : 32'd0;
                m_last  = last_beat;
            end
            default: ;
        endcase
    end

    // Frame counters: read address, beats sent, word position in packet
    always_ff @(posedge clk) begin
        if (!nreset) begin
            tris_q    <= '0;
            rd_addr_q <= '0;
            xfer_cnt  <= '0;
            wcnt      <= '0;
        end else if (start_acc) begin
            tris_q    <= tris_clamped;
            rd_addr_q <= '0;
            xfer_cnt  <= '0;
            wcnt      <= '0;
        end else begin
            if (rd_en) rd_addr_q <= rd_addr_q + 9'd1;
            if (xfer) begin
                xfer_cnt <= xfer_cnt + 10'd1;
                wcnt     <= last_beat ? 4'd0 : wcnt + 4'd1;
            end
        end
    end

    // In-flight read tracker; the oldest stage marks rd_data as valid
    always_ff @(posedge clk) begin
        if (!nreset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            for (int i = 1; i < BRAM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Done pulses in the first IDLE cycle after the end packet's last beat
    always_ff @(posedge clk) begin
        if (!nreset) done <= 1'b0;
        else         done <= (state == END_PKT) && xfer && last_beat;
    end

    tri_prefetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (vld_pipe[BRAM_LATENCY-1]),
        .pop    (fifo_pop),
        .din    (rd_data),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .empty  (fifo_empty)
    );

`ifdef TRI_STREAM_STALL_CNT_EN
    // Saturating count of cycles where the cores back-pressure a valid word
    always_ff @(posedge clk) begin
        if (!nreset)
            stall_cycles <= '0;
        else if (start_acc)
            stall_cycles <= '0;
        else if (busy && m_valid && !m_ready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_tri_stream_tx.sv
// Scoreboard bench for tri_stream_tx: stimulus queues expected beats, a
// monitor pops and compares each transferred beat and every BRAM read.
module tb_tri_stream_tx;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  tri_count = '0;
    logic        busy, done, rd_en;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
`ifdef TRI_STREAM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          is_end;
        bit          fin;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       b;
    logic [31:0] mem [512];
    logic [31:0] bram_pipe [LAT];

    int errors = 0, checks = 0;
    int beats = 0, done_cnt = 0, exp_addr = 0, outstanding = 0, frame_words = 0;
    bit expect_done = 0, prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    // BRAM model: data valid LAT cycles after the read is issued
    always @(posedge clk) begin
        bram_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign rd_data = bram_pipe[LAT-1];

    tri_stream_tx dut (
        .clk       (clk),
        .nreset    (nreset),
        .start     (start),
        .tri_count (tri_count),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef TRI_STREAM_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // mode: 0 ready high, 1 random ready, 2 start re-pulse, 3 reset at beat 13, 4 stall 7 at word 4
    task automatic run_frame(input int cnt, input int mode);
        int n, d0, cyc, first_v, stall_left;
        bit stalled, did_reset;
        n = (cnt > 51) ? 51 : cnt;
        d0 = done_cnt;
        frame_words = n * 10;
        for (int i = 0; i < n; i++)
            for (int w = 0; w < 10; w++)
                exp_q.push_back('{mem[i*10+w], (w == 9), 1'b0, 1'b0});
        for (int w = 0; w < 10; w++)
            exp_q.push_back('{(w == 0) ? 32'h0000_0FFF : 32'd0, (w == 9), 1'b1, (w == 9)});
        @(posedge clk); #1;
        start = 1'b1; tri_count = 6'(cnt); m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; first_v = 0; stall_left = 0; stalled = 0; did_reset = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            if (first_v == 0 && m_valid === 1'b1) first_v = cyc;
            case (mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (cyc == 6) begin start = 1'b1; tri_count = 6'd5; end
                    else start = 1'b0;
                end
                3: if (beats == 13) begin
                    nreset = 1'b0; m_ready = 1'b0;
                    @(posedge clk); #1;
                    nreset = 1'b1;
                    chk("abort_m_valid", 32'(m_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    did_reset = 1;
                    break;
                end
                4: begin
                    if (!stalled && beats == 4) begin stall_left = 7; stalled = 1; end
                    m_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                default: m_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (first_v < 1 || first_v > LAT + 2) begin
            errors++;
            $display("FAIL first_valid_latency got=%0d exp<=%0d", first_v, LAT + 2);
        end
        if (mode == 3) begin
            checks++;
            if (!did_reset) begin errors++; $display("FAIL abort_timeout got=no_beat13 exp=beat13"); end
        end else begin
            checks++;
            if (done_cnt == d0) begin errors++; $display("FAIL frame_timeout cnt=%0d got=no_done exp=done", cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000 + 32'(i);
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!nreset) begin
                        exp_q.delete();
                        beats = 0; exp_addr = 0; outstanding = 0;
                        expect_done = 0; prev_stall = 0;
                    end else begin
                        if (expect_done || done === 1'b1) begin
                            checks++;
                            if (done !== expect_done || busy !== 1'b0) begin
                                errors++;
                                $display("FAIL done_pulse got done=%b busy=%b exp done=%b busy=0", done, busy, expect_done);
                            end
                            if (expect_done) begin
                                checks++;
                                if (exp_addr != frame_words) begin
                                    errors++;
                                    $display("FAIL read_count got=%0d exp=%0d", exp_addr, frame_words);
                                end
                                done_cnt++;
                                exp_addr = 0; outstanding = 0; beats = 0;
                            end
                            expect_done = 0;
                        end
                        if (prev_stall) begin
                            checks++;
                            if (!(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)) begin
                                errors++;
                                $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                         m_valid, m_data, m_last, prev_data, prev_last);
                            end
                        end
                        if (rd_en === 1'b1) begin
                            checks++;
                            if (exp_addr >= frame_words || rd_addr !== 9'(exp_addr) || outstanding >= 4) begin
                                errors++;
                                $display("FAIL bram_read got addr=%0d outstanding=%0d exp addr=%0d (<%0d) outstanding<4",
                                         rd_addr, outstanding, exp_addr, frame_words);
                            end
                            exp_addr++;
                            outstanding++;
                        end
                        if (m_valid === 1'b1 && m_ready === 1'b1) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_beat got=%h exp=none", m_data);
                            end else begin
                                b = exp_q.pop_front();
                                if (m_data !== b.data || m_last !== b.last) begin
                                    errors++;
                                    $display("FAIL beat got d=%h l=%b exp d=%h l=%b", m_data, m_last, b.data, b.last);
                                end
                                if (!b.is_end) outstanding--;
                                if (b.fin) expect_done = 1;
                            end
                            beats++;
                        end
                        prev_stall = (m_valid === 1'b1 && m_ready !== 1'b1);
                        prev_data  = m_data;
                        prev_last  = m_last;
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                nreset = 1'b1;
                chk("rst_busy",    32'(busy),    32'd0);
                chk("rst_done",    32'(done),    32'd0);
                chk("rst_rd_en",   32'(rd_en),   32'd0);
                chk("rst_rd_addr", 32'(rd_addr), 32'd0);
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_m_data",  m_data,       32'd0);
                chk("rst_m_last",  32'(m_last),  32'd0);

                run_frame(1, 0);     // one triangle, ready held high
                run_frame(0, 0);     // end packet only, no reads
                run_frame(3, 1);     // random back-pressure
                run_frame(2, 2);     // start re-pulsed mid-frame is ignored
                run_frame(2, 3);     // reset aborts at beat 13
                run_frame(1, 0);     // fresh frame restarts at address 0
                run_frame(60, 0);    // clamped to 51 triangles
                run_frame(1, 4);     // 7-cycle stall on word 4
`ifdef TRI_STREAM_STALL_CNT_EN
                chk("stall_cycles", stall_cycles, 32'd7);
`endif
                repeat (3) @(posedge clk);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
